// File: rtl/prng_pkg.sv
// Shared definitions for the dice-roll controller that consumes the PRNG byte stream.
package prng_pkg;

  localparam int RND_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROLL   = 2'd1,
    REDUCE = 2'd2,
    HOLD   = 2'd3
  } roll_state_t;

  function automatic logic is_busy(input roll_state_t s);
    return (s == ROLL) || (s == REDUCE);
  endfunction

endpackage

// File: rtl/prng_roll_ctrl_btn_debounce.sv
// Push-button conditioning: two-flop synchronizer, stable-level debouncer and a
// single-cycle pulse on each accepted rising edge.
module btn_debounce #(
  parameter logic [15:0] DB_CYCLES = 16'd50000
) (
  input  logic CLK,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic press
);

  logic        sync1;
  logic        sync2;
  logic        level_d;
  logic [15:0] stable_cnt;

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Any cycle where the synchronized input agrees with the accepted level restarts the count.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      btn_level  <= 1'b0;
      stable_cnt <= '0;
    end else if (sync2 == btn_level) begin
      stable_cnt <= '0;
    end else if (stable_cnt >= DB_CYCLES - 16'd1) begin
      btn_level  <= sync2;
      stable_cnt <= '0;
    end else begin
      stable_cnt <= stable_cnt + 16'd1;
    end
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      level_d <= 1'b0;
    end else begin
      level_d <= btn_level;
    end
  end

  assign press = btn_level & ~level_d;

endmodule

// File: rtl/prng_roll_ctrl.sv
// Dice-roll controller: animates the PRNG byte for a fixed number of samples on a
// button press, then reduces the last sample modulo a latched range and holds it.
module prng_roll_ctrl
  import prng_pkg::*;
#(
  parameter logic [15:0] DB_CYCLES    = 16'd50000,
  parameter logic [3:0]  ROLL_SAMPLES = 4'd8
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             en,
  input  logic [RND_W-1:0] rnd_data,
  input  logic             rnd_valid,
  input  logic             btn,
  input  logic [RND_W-1:0] range,
  output logic [RND_W-1:0] disp_val,
  output logic             disp_valid,
  output logic             rolling,
  output logic             busy
);

  localparam logic [3:0] ROLL_LAST = ROLL_SAMPLES - 4'd1;

  roll_state_t      state;
  roll_state_t      state_n;
  logic [3:0]       sample_cnt;
  logic [3:0]       sample_cnt_n;
  logic [RND_W-1:0] work;
  logic [RND_W-1:0] work_n;
  logic [RND_W-1:0] rng_q;
  logic [RND_W-1:0] rng_n;
  logic [RND_W-1:0] disp_n;
  logic             btn_level;
  logic             press;
  logic             press_ok;

  btn_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_debounce (
    .CLK       (CLK),
    .rst       (rst),
    .btn_raw   (btn),
    .btn_level (btn_level),
    .press     (press)
  );

  assign press_ok = press & btn_level;

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      sample_cnt <= '0;
      work       <= '0;
      rng_q      <= '0;
      disp_val   <= '0;
    end else begin
      state      <= state_n;
      sample_cnt <= sample_cnt_n;
      work       <= work_n;
      rng_q      <= rng_n;
      disp_val   <= disp_n;
    end
  end

  // Enable overrides every state; REDUCE is only entered with a nonzero modulus so it always terminates.
  always_comb begin
    state_n      = state;
    sample_cnt_n = sample_cnt;
    work_n       = work;
    rng_n        = rng_q;
    disp_n       = disp_val;
    if (!en) begin
      state_n      = IDLE;
      sample_cnt_n = '0;
      disp_n       = '0;
    end else begin
      case (state)
        IDLE: begin
          disp_n = '0;
          if (press_ok) begin
            rng_n        = range;
            sample_cnt_n = '0;
            state_n      = ROLL;
          end
        end
        ROLL: begin
          if (rnd_valid) begin
            disp_n = rnd_data;
            if (sample_cnt == ROLL_LAST) begin
              work_n       = rnd_data;
              sample_cnt_n = '0;
              state_n      = (rng_q == '0) ? HOLD : REDUCE;
            end else begin
              sample_cnt_n = sample_cnt + 4'd1;
            end
          end
        end
        REDUCE: begin
          if (work >= rng_q) begin
            work_n = work - rng_q;
          end else begin
            disp_n  = work;
            state_n = HOLD;
          end
        end
        HOLD: begin
          if (press_ok) begin
            rng_n        = range;
            sample_cnt_n = '0;
            state_n      = ROLL;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign disp_valid = (state == HOLD);
  assign rolling    = (state == ROLL);
  assign busy       = is_busy(state);

endmodule

// File: tb/tb_prng_roll_ctrl.sv
// Directed bench for prng_roll_ctrl with a short debounce window and three-sample rolls.
module tb_prng_roll_ctrl;

  logic       CLK = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] rnd_data;
  logic       rnd_valid;
  logic       btn;
  logic [7:0] range;
  logic [7:0] disp_val;
  logic       disp_valid;
  logic       rolling;
  logic       busy;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 CLK = ~CLK;

  prng_roll_ctrl #(
    .DB_CYCLES    (16'd4),
    .ROLL_SAMPLES (4'd3)
  ) dut (
    .CLK        (CLK),
    .rst        (rst),
    .en         (en),
    .rnd_data   (rnd_data),
    .rnd_valid  (rnd_valid),
    .btn        (btn),
    .range      (range),
    .disp_val   (disp_val),
    .disp_valid (disp_valid),
    .rolling    (rolling),
    .busy       (busy)
  );

  typedef struct {
    logic [7:0] rng;
    logic [7:0] s0;
    logic [7:0] s1;
    logic [7:0] s_final;
    logic [7:0] exp_val;
    int         exp_cycles;
    string      name;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic pressButton(input string name, output int lat);
    btn = 1'b1;
    lat = 0;
    while (!rolling && lat < 20) begin
      tick();
      lat++;
    end
    checkOutput({name, " enters ROLL"}, 32'(rolling), 32'd1);
    checkOutput({name, " valid low in ROLL"}, 32'(disp_valid), 32'd0);
    btn = 1'b0;
    repeat (8) tick();
  endtask

  task automatic sendSample(input logic [7:0] d);
    rnd_data  = d;
    rnd_valid = 1'b1;
    tick();
    rnd_valid = 1'b0;
  endtask

  task automatic waitResult(output int cyc);
    cyc = 0;
    while (!disp_valid && cyc < 400) begin
      tick();
      cyc++;
    end
  endtask

  task automatic applyStimulus(input int idx);
    vec_t v;
    int   lat;
    int   cyc;
    v     = vecs[idx];
    range = v.rng;
    pressButton(v.name, lat);
    sendSample(v.s0);
    checkOutput({v.name, " sample0"}, 32'(disp_val), 32'(v.s0));
    sendSample(v.s1);
    checkOutput({v.name, " sample1"}, 32'(disp_val), 32'(v.s1));
    sendSample(v.s_final);
    checkOutput({v.name, " busy after final"}, 32'(busy), (v.exp_cycles > 0) ? 32'd1 : 32'd0);
    waitResult(cyc);
    checkOutput({v.name, " result"}, 32'(disp_val), 32'(v.exp_val));
    checkOutput({v.name, " reduce cycles"}, 32'(cyc), 32'(v.exp_cycles));
    checkOutput({v.name, " busy in HOLD"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat;
    int cyc;
    int rolled;
    int dropped;

    vecs[0] = '{8'd6,   8'h11, 8'h22, 8'h17, 8'd5,  4,   "mod6_23"};
    vecs[1] = '{8'd0,   8'h01, 8'h02, 8'hA5, 8'hA5, 0,   "bypass_A5"};
    vecs[2] = '{8'd1,   8'h33, 8'h44, 8'hFF, 8'd0,  256, "mod1_255"};
    vecs[3] = '{8'd255, 8'h55, 8'h66, 8'hFF, 8'd0,  2,   "mod255_255"};
    vecs[4] = '{8'd10,  8'h00, 8'h00, 8'h63, 8'd9,  10,  "mod10_99"};
    vecs[5] = '{8'd7,   8'h00, 8'h00, 8'h06, 8'd6,  1,   "mod7_6"};

    rst       = 1'b0;
    en        = 1'b1;
    btn       = 1'b0;
    rnd_valid = 1'b0;
    rnd_data  = 8'h00;
    range     = 8'd0;
    #3;
    checkOutput("reset disp_val", 32'(disp_val), 32'd0);
    checkOutput("reset disp_valid", 32'(disp_valid), 32'd0);
    checkOutput("reset rolling", 32'(rolling), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    repeat (2) tick();
    rst = 1'b1;
    tick();

    // Bouncing button: 2-cycle toggles must not produce a press.
    range  = 8'd6;
    rolled = 0;
    for (int i = 0; i < 10; i++) begin
      btn = ~btn;
      repeat (2) begin
        tick();
        if (rolling) rolled++;
      end
    end
    checkOutput("bounce no press", 32'(rolled), 32'd0);
    pressButton("clean press", lat);
    checkOutput("press latency in 6..8", (lat >= 6 && lat <= 8) ? 32'd1 : 32'd0, 32'd1);

    // Second press and a range change mid-roll must both be ignored.
    sendSample(8'h11);
    checkOutput("ignored roll s0", 32'(disp_val), 32'h11);
    btn = 1'b1;
    repeat (8) tick();
    btn = 1'b0;
    repeat (8) tick();
    checkOutput("press in ROLL still rolling", 32'(rolling), 32'd1);
    checkOutput("press in ROLL disp kept", 32'(disp_val), 32'h11);
    range = 8'd2;
    sendSample(8'h22);
    checkOutput("ignored roll s1", 32'(disp_val), 32'h22);
    checkOutput("ignored roll still rolling", 32'(rolling), 32'd1);
    sendSample(8'h17);
    waitResult(cyc);
    checkOutput("latched range result", 32'(disp_val), 32'd5);
    checkOutput("latched range cycles", 32'(cyc), 32'd4);

    // Short glitches while holding must leave the result in place.
    dropped = 0;
    for (int i = 0; i < 5; i++) begin
      btn = 1'b1;
      repeat (3) begin
        tick();
        if (!disp_valid) dropped++;
      end
      btn = 1'b0;
      repeat (3) begin
        tick();
        if (!disp_valid) dropped++;
      end
    end
    repeat (8) tick();
    checkOutput("glitch no press", 32'(dropped), 32'd0);
    checkOutput("glitch hold value", 32'(disp_val), 32'd5);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(i);
    end

    // Enable dropped during REDUCE.
    range = 8'd1;
    pressButton("en test", lat);
    sendSample(8'h01);
    sendSample(8'h02);
    sendSample(8'hFF);
    repeat (10) tick();
    checkOutput("en test busy in REDUCE", 32'(busy), 32'd1);
    checkOutput("en test disp in REDUCE", 32'(disp_val), 32'hFF);
    en = 1'b0;
    tick();
    checkOutput("en low busy", 32'(busy), 32'd0);
    checkOutput("en low rolling", 32'(rolling), 32'd0);
    checkOutput("en low disp_valid", 32'(disp_valid), 32'd0);
    checkOutput("en low disp_val", 32'(disp_val), 32'd0);
    en = 1'b1;
    repeat (3) tick();
    checkOutput("en restored idle", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of a roll.
    range = 8'd6;
    pressButton("reset test", lat);
    sendSample(8'h42);
    checkOutput("reset test s0", 32'(disp_val), 32'h42);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async reset disp_val", 32'(disp_val), 32'd0);
    checkOutput("async reset rolling", 32'(rolling), 32'd0);
    checkOutput("async reset busy", 32'(busy), 32'd0);
    checkOutput("async reset disp_valid", 32'(disp_valid), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    sendSample(8'h99);
    checkOutput("post reset idle disp_val", 32'(disp_val), 32'd0);
    checkOutput("post reset idle rolling", 32'(rolling), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
